// File: rtl/mock2_pkg.sv
// Shared types and constants for the Mock2 bit-serial adder.
// Holds the default operand width, the FSM state type and the counter width helper.
package mock2_pkg;

  localparam int MOCK2_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mock2_state_e;

  // Bit counter spans 0..width-1; keep at least one bit for degenerate widths.
  function automatic int mock2_cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int MOCK2_CNT_W = mock2_cnt_width(MOCK2_WIDTH);

endpackage

// File: rtl/mock2_full_adder_1b.sv
// Single-bit combinational full adder, time-shared across every bit-cycle
// of the serial adder.
module mock2_full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic half_s;

  assign half_s = a ^ b;
  assign s      = half_s ^ ci;
  assign co     = (a & b) | (ci & half_s);

endmodule

// File: rtl/mock2_serial_adder.sv
// Bit-serial {Cin, A, B} -> {Cout, S} adder behind request/response handshakes.
// Optional signed-overflow output enabled by defining MOCK2_SERIAL_OVF_EN.
module mock2_serial_adder
  import mock2_pkg::*;
#(
  parameter int WIDTH = MOCK2_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Req_Valid,
  output logic             Req_Ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Rsp_Valid,
  input  logic             Rsp_Ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef MOCK2_SERIAL_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int               CNT_W    = mock2_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  mock2_state_e     state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] s_r;
  logic             carry_r;
  logic             cout_r;
  logic             req_ready_r;
  logic             rsp_valid_r;
  logic             fa_s;
  logic             fa_co;
`ifdef MOCK2_SERIAL_OVF_EN
  logic             ovf_r;
`endif

  mock2_full_adder_1b u_fa (
    .a  (a_sh_r[0]),
    .b  (b_sh_r[0]),
    .ci (carry_r),
    .s  (fa_s),
    .co (fa_co)
  );

  // Transaction FSM: capture, LSB-first accumulation, and held response.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      a_sh_r      <= {WIDTH{1'b0}};
      b_sh_r      <= {WIDTH{1'b0}};
      s_r         <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      cout_r      <= 1'b0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
`ifdef MOCK2_SERIAL_OVF_EN
      ovf_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (Req_Valid && req_ready_r) begin
            a_sh_r      <= A;
            b_sh_r      <= B;
            carry_r     <= Cin;
            cnt_r       <= {CNT_W{1'b0}};
            s_r         <= {WIDTH{1'b0}};
            cout_r      <= 1'b0;
            req_ready_r <= 1'b0;
            state_r     <= RUN;
`ifdef MOCK2_SERIAL_OVF_EN
            ovf_r       <= 1'b0;
`endif
          end else begin
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
          end
        end
        RUN: begin
          // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
          s_r     <= {fa_s, s_r[WIDTH-1:1]};
          a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
          carry_r <= fa_co;
          cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == LAST_BIT) begin
            cout_r      <= fa_co;
            rsp_valid_r <= 1'b1;
            state_r     <= DONE;
`ifdef MOCK2_SERIAL_OVF_EN
            // carry_r here is the carry into the MSB position.
            ovf_r       <= carry_r ^ fa_co;
`endif
          end else begin
            rsp_valid_r <= 1'b0;
          end
        end
        DONE: begin
          if (Rsp_Ready) begin
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
            state_r     <= IDLE;
          end else begin
            rsp_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= {CNT_W{1'b0}};
          req_ready_r <= 1'b1;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign Req_Ready = req_ready_r;
  assign Rsp_Valid = rsp_valid_r;
  assign S         = s_r;
  assign Cout      = cout_r;
`ifdef MOCK2_SERIAL_OVF_EN
  assign Ovf       = ovf_r;
`endif

endmodule
